// File: rtl/serial_fa_adder_pkg.sv
// Shared types and constants for the bit-serial full-adder datapath.
//   state_t     : controller states (ST_IDLE, ST_SHIFT, ST_DONE)
//   WIDTH_MAX   : largest supported operand width
//   cnt_width() : bit count for the bit-position counter, able to hold 0..width
package serial_fa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MAX = 32;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_fa_adder_fa_cell.sv
// Purely combinational 1-bit full adder.
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   co        : carry-out (majority of the three inputs)
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_fa_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry,
// processing one operand bit per clock, LSB first.
// Optional feature: define SERIAL_FA_OVF_EN to add the signed-overflow output.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request an operation; accepted only in idle
//   a, b  : operands, captured on an accepted start
//   cin   : carry-in, captured on an accepted start
//   busy  : high while bits are being processed
//   done  : one-cycle pulse when sum/cout (and ovf) are updated
//   sum   : registered result, held until the next operation completes
//   cout  : registered carry-out of the MSB
//   ovf   : registered signed overflow (SERIAL_FA_OVF_EN only)
module serial_fa_adder
    import serial_fa_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_FA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_fa_adder: WIDTH out of range");
    end

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             carry, carry_nxt;
    logic [WIDTH-1:0] a_sr, a_sr_nxt;
    logic [WIDTH-1:0] b_sr, b_sr_nxt;
    logic [WIDTH-1:0] sum_sr, sum_sr_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic             busy_nxt, done_nxt, cout_nxt;
`ifdef SERIAL_FA_OVF_EN
    logic             ovf_nxt;
`endif

    logic             bit_s_c, bit_co_c;
    logic [WIDTH:0]   sum_cat_c;

    // Single shared full-adder cell operating on the current LSBs.
    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (bit_s_c),
        .co  (bit_co_c)
    );

    // New sum bit enters at the MSB; bits [WIDTH:1] are the shifted register.
    assign sum_cat_c = {bit_s_c, sum_sr};

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        carry_nxt  = carry;
        a_sr_nxt   = a_sr;
        b_sr_nxt   = b_sr;
        sum_sr_nxt = sum_sr;
        sum_nxt    = sum;
        cout_nxt   = cout;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
`ifdef SERIAL_FA_OVF_EN
        ovf_nxt    = ovf;
`endif

        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_sr_nxt  = a;
                    b_sr_nxt  = b;
                    carry_nxt = cin;
                    count_nxt = '0;
                    state_nxt = ST_SHIFT;
                    busy_nxt  = 1'b1;
                end
            end
            ST_SHIFT: begin
                carry_nxt  = bit_co_c;
                a_sr_nxt   = a_sr >> 1;
                b_sr_nxt   = b_sr >> 1;
                sum_sr_nxt = sum_cat_c[WIDTH:1];
                count_nxt  = count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    // Last bit: publish the result together with the done pulse.
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    sum_nxt   = sum_cat_c[WIDTH:1];
                    cout_nxt  = bit_co_c;
`ifdef SERIAL_FA_OVF_EN
                    // Carry into the MSB is the carry register on this cycle.
                    ovf_nxt   = carry ^ bit_co_c;
`endif
                end else begin
                    busy_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SERIAL_FA_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            carry  <= carry_nxt;
            a_sr   <= a_sr_nxt;
            b_sr   <= b_sr_nxt;
            sum_sr <= sum_sr_nxt;
            sum    <= sum_nxt;
            cout   <= cout_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
`ifdef SERIAL_FA_OVF_EN
            ovf    <= ovf_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_fa_adder.sv
// Self-checking bench for serial_fa_adder: an 8-bit instance checked every
// cycle against a phase/arithmetic model, plus an exhaustive 4-bit instance.
`timescale 1ns/1ps
module tb_serial_fa_adder;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
`ifdef SERIAL_FA_OVF_EN
    logic       ovf8, ovf4;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    serial_fa_adder #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_FA_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_fa_adder #(.WIDTH(W4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SERIAL_FA_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the 8-bit instance: phase 0 idle, 1..W8 busy, W8+1 done.
    int         m_phase;
    logic [8:0] m_pend;
    logic       m_povf;
    logic [7:0] m_sum;
    logic       m_cout, m_ovf;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_sum   = 8'h00;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_phase == 0) begin
            if (start8 === 1'b1) begin
                m_phase = 1;
                m_pend  = 9'(a8) + 9'(b8) + 9'(cin8);
                m_povf  = (a8[7] == b8[7]) && (m_pend[7] != a8[7]);
            end
        end else if (m_phase == W8) begin
            m_phase = W8 + 1;
            m_sum   = m_pend[7:0];
            m_cout  = m_pend[8];
            m_ovf   = m_povf;
        end else if (m_phase == W8 + 1) begin
            m_phase = 0;
        end else begin
            m_phase++;
        end
    end

    // Per-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m8_busy", 64'(busy8), 64'(m_phase >= 1 && m_phase <= W8));
            chk("m8_done", 64'(done8), 64'(m_phase == W8 + 1));
            chk("m8_sum",  64'(sum8),  64'(m_sum));
            chk("m8_cout", 64'(cout8), 64'(m_cout));
`ifdef SERIAL_FA_OVF_EN
            chk("m8_ovf",  64'(ovf8),  64'(m_ovf));
`endif
        end
    end

    // Runs one 8-bit operation; checks latency, busy length and literal results.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo, input string tag);
        int n;
        int bc;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n  = 1;
        bc = 0;
        while (done8 !== 1'b1 && n < 40) begin
            bc += int'(busy8);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(9));
        chk({tag, "_busycyc"}, 64'(bc), 64'(8));
        chk({tag, "_sum"}, 64'(sum8), 64'(es));
        chk({tag, "_cout"}, 64'(cout8), 64'(ec));
`ifdef SERIAL_FA_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf8), 64'(eo));
`else
        if (eo) begin end
`endif
        @(negedge clk);
        chk({tag, "_done_once"}, 64'(done8), 64'(0));
    endtask

    // Runs one 4-bit operation and checks it against plain arithmetic.
    task automatic op4(input int a, input int b, input int c);
        int         n;
        logic [4:0] exp;
        exp = 5'(a) + 5'(b) + 5'(c);
        a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("x4_latency", 64'(n), 64'(5));
        chk("x4_result", 64'({cout4, sum4}), 64'(exp));
`ifdef SERIAL_FA_OVF_EN
        chk("x4_ovf", 64'(ovf4), 64'((a4[3] == b4[3]) && (exp[3] != a4[3])));
`endif
        @(negedge clk);
        chk("x4_done_once", 64'(done4), 64'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy8), 64'(0));
        chk("rst_done", 64'(done8), 64'(0));
        chk("rst_sum",  64'(sum8),  64'(0));
        chk("rst_cout", 64'(cout8), 64'(0));
        chk("rst_sum4", 64'(sum4),  64'(0));
        rst = 1'b0;
        @(negedge clk);

        op8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, "add5a33");
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "addff01");
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "addffff1");

        // Start while busy is ignored.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            dc += int'(done8);
            @(negedge clk);
        end
        chk("busy_ign_dones", 64'(dc), 64'(1));
        chk("busy_ign_sum", 64'(sum8), 64'(8'h30));
        chk("busy_ign_cout", 64'(cout8), 64'(0));

        // Start during the done cycle is ignored.
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 40 && done8 !== 1'b1; i++) @(negedge clk);
        chk("done_seen", 64'(done8), 64'(1));
        a8 = 8'h0F; b8 = 8'h0F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("done_ign_busy", 64'(busy8), 64'(0));
            @(negedge clk);
        end
        chk("done_ign_sum", 64'(sum8), 64'(8'h02));

        // Reset mid-operation aborts with no done pulse.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy8), 64'(0));
        chk("abort_done", 64'(done8), 64'(0));
        chk("abort_sum",  64'(sum8),  64'(0));
        chk("abort_cout", 64'(cout8), 64'(0));
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            dc += int'(done8);
            @(negedge clk);
        end
        chk("abort_nodone", 64'(dc), 64'(0));

        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf7f01");
        op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "ovf8080");
        op8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, "ovf0503");

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(a, b, c);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
